dbus_access_unit: RTL
=====================

// Module: dbus_access_unit
// PURPOSE
//  Memory-stage data-bus engine of the 5-stage pipeline. Sits between the execute->memory pipeline register and dbus.
//  Issues one dreq per load/store and holds it stable until dresp.data_ok.
//  Aligns store data/strobe and extracts/extends load data for writeback; stalls upstream while the bus is busy.
// PARAMETERS
//  XLEN     64  datapath width (word_t); only 64 is supported
//  MAX_WAIT 0   0 = unbounded wait for data_ok; >0 raises bus_timeout after MAX_WAIT busy cycles
// PORTS
//  clk          in   1    pipeline clock
//  reset        in   1    asynchronous, active-low (0 = reset); one clock domain
//  in_valid     in   1    memory-stage instruction valid
//  in_op        in   2    00 none, 01 load, 10 store (MemRW encoding); 11 treated as none
//  in_size      in   2    msize_t: 0 byte, 1 half, 2 word, 3 dword
//  in_unsigned  in   1    load zero-extends when 1, sign-extends when 0
//  in_addr      in   64   effective address (ALU result)
//  in_wdata     in   64   store data (rs2), value in low bytes
//  flush        in   1    discard the current memory-stage instruction
//  dreq         out  dbus_req_t  valid/addr/size/strobe/data
//  dresp        in   dbus_resp_t addr_ok/data_ok/data; only data_ok and data are used
//  stall        out  1    hold all stages at and before memory
//  out_valid    out  1    access completed this cycle; result is valid
//  out_rdata    out  64   aligned, extended load result (0 for stores)
//  misaligned   out  1    address not size-aligned; no bus access made
//  bus_timeout  out  1    sticky until reset; only when MAX_WAIT>0
// BEHAVIOUR
//  Reset (async): state=IDLE, drop=0, wait counter=0, bus_timeout=0.
//   While reset is low, dreq.valid, stall, out_valid and misaligned are all 0.
//  FSM IDLE/BUSY.
//  - IDLE, accept = in_valid & op in {01,10} & aligned & ~flush:
//    drive dreq from the inputs in the same cycle (zero-latency issue) and latch the request.
//    If data_ok in that cycle: out_valid=1, stall=0, stay IDLE. Otherwise stall=1 and go to BUSY.
//  - BUSY: drive dreq from the latched copy only; it is bit-stable until data_ok.
//    stall=1 until the data_ok cycle; on data_ok, stall=0, out_valid=~drop, then go to IDLE.
//  - flush in IDLE: no access is issued.
//    flush in BUSY: set drop. The bus transaction still completes (it is never withdrawn), out_valid is suppressed.
//  - Alignment: aligned = (addr & ((1<<size)-1)) == 0.
//    Misaligned with in_valid and op!=none: misaligned=1 (combinational), no dreq, stall=0, out_valid=0.
//  - Store: strobe = ((1<<(1<<size))-1) << addr[2:0]; data = in_wdata << (addr[2:0]*8).
//  - Load: strobe=0. shifted = dresp.data >> (addr[2:0]*8), truncated to the size and then extended.
//    out_rdata is combinational from dresp.data during the data_ok cycle and 0 otherwise.
//  - Wait counter increments each BUSY cycle and clears on data_ok.
//    Reaching MAX_WAIT sets bus_timeout; the FSM keeps waiting.
//  - in_* may change while BUSY; they are ignored until the FSM returns to IDLE.
//  - Reset mid-BUSY: dreq.valid drops immediately, and the latched request and drop are discarded.
//  - Back-to-back: a new access is accepted in the IDLE cycle right after completion; there is no bubble beyond the stall.
// STRUCTURE
//  Package pipes gains: mem_op_t enum (NONE/LOAD/STORE), msize_t, dau_state_t (IDLE/BUSY),
//   and a latched-request struct {addr, size, unsigned, op, wdata}.
//  Sub-module mem_align (combinational): store strobe/data generation, plus load shift and sign/zero extension.
//  dbus_access_unit owns the FSM, the request latch, the drop flag and the wait counter.
// TESTING
//  1. Store byte, addr 0x8000_1003, wdata 0xAB, data_ok after 2 cycles -> strobe 8'b0000_1000, data[31:24]=0xAB.
//     dreq is stable and stall=1 for 2 cycles, then out_valid=1.
//  2. Signed half load, addr ..06, dresp.data 0x8001_0000_0000_0000 -> out_rdata 0xFFFF_FFFF_FFFF_8001.
//     Same access with in_unsigned=1 -> 0x0000_0000_0000_8001.
//  3. Zero-wait dword load with data_ok in the issue cycle -> out_valid=1 and stall=0 in the same cycle; a second load is issued the next cycle.
//  4. Word load at addr ..02 -> misaligned=1, dreq.valid=0, stall=0, out_valid=0.
//  5. flush asserted in BUSY, data_ok after 3 cycles -> dreq unchanged throughout, out_valid stays 0, FSM returns to IDLE.
//  6. reset driven low during BUSY -> dreq.valid=0 asynchronously.
//     After release, a store at 0x8000_0000 is issued normally; with MAX_WAIT=4 and no data_ok, bus_timeout rises after 4 cycles.

Source files
------------

// File: rtl/pipes_pkg.sv
// Shared pipeline types used by the memory-stage data-bus engine and its helpers.
package pipes;

    typedef logic [63:0] word_t;

    typedef enum logic [1:0] {
        MEM_NONE  = 2'b00,
        MEM_LOAD  = 2'b01,
        MEM_STORE = 2'b10
    } mem_op_t;

    typedef enum logic [1:0] {
        MSIZE1 = 2'd0,
        MSIZE2 = 2'd1,
        MSIZE4 = 2'd2,
        MSIZE8 = 2'd3
    } msize_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } dau_state_t;

    typedef struct packed {
        logic       valid;
        word_t      addr;
        msize_t     size;
        logic [7:0] strobe;
        word_t      data;
    } dbus_req_t;

    typedef struct packed {
        logic  addr_ok;
        logic  data_ok;
        word_t data;
    } dbus_resp_t;

    typedef struct packed {
        word_t   addr;
        msize_t  size;
        logic    is_unsigned;
        mem_op_t op;
        word_t   wdata;
    } mem_req_t;

    function automatic logic is_aligned(input logic [2:0] lo, input msize_t size);
        logic ok;
        case (size)
            MSIZE1:  ok = 1'b1;
            MSIZE2:  ok = (lo[0] == 1'b0);
            MSIZE4:  ok = (lo[1:0] == 2'b00);
            default: ok = (lo == 3'b000);
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/mem_align.sv
// Byte-lane alignment: store strobe/data placement and load shift plus sign/zero extension.
module mem_align
    import pipes::*;
(
    input  msize_t     size,
    input  logic [2:0] offset,
    input  logic       is_unsigned,
    input  word_t      wdata,
    input  word_t      rdata,
    output logic [7:0] strobe,
    output word_t      wdata_out,
    output word_t      rdata_out
);

    word_t      shifted;
    logic [7:0] lanes;

    always_comb begin
        lanes     = 8'h00;
        rdata_out = '0;
        case (size)
            MSIZE1:  lanes = 8'h01;
            MSIZE2:  lanes = 8'h03;
            MSIZE4:  lanes = 8'h0F;
            default: lanes = 8'hFF;
        endcase
        strobe    = lanes << offset;
        wdata_out = wdata << {offset, 3'b000};
        shifted   = rdata >> {offset, 3'b000};
        case (size)
            MSIZE1:  rdata_out = {{56{~is_unsigned & shifted[7]}},  shifted[7:0]};
            MSIZE2:  rdata_out = {{48{~is_unsigned & shifted[15]}}, shifted[15:0]};
            MSIZE4:  rdata_out = {{32{~is_unsigned & shifted[31]}}, shifted[31:0]};
            default: rdata_out = shifted;
        endcase
    end

endmodule

// File: rtl/dbus_access_unit.sv
// Memory-stage data-bus engine: issues one dbus request per load/store, holds it until data_ok,
// stalls upstream meanwhile and returns the aligned, extended load result.
module dbus_access_unit
    import pipes::*;
#(
    parameter int XLEN     = 64,
    parameter int MAX_WAIT = 0
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            in_valid,
    input  logic [1:0]      in_op,
    input  logic [1:0]      in_size,
    input  logic            in_unsigned,
    input  logic [XLEN-1:0] in_addr,
    input  logic [XLEN-1:0] in_wdata,
    input  logic            flush,
    output dbus_req_t       dreq,
    input  dbus_resp_t      dresp,
    output logic            stall,
    output logic            out_valid,
    output logic [XLEN-1:0] out_rdata,
    output logic            misaligned,
    output logic            bus_timeout,
    output dau_state_t      dbg_state
);

    localparam logic [31:0] MAX_W = 32'(MAX_WAIT);

    dau_state_t  state;
    mem_req_t    req_q;
    mem_req_t    in_req;
    mem_req_t    cur;
    logic        drop;
    logic [31:0] wait_cnt;

    logic        in_mem;
    logic        in_aligned;
    logic        accept;
    logic        active;
    logic [7:0]  al_strobe;
    word_t       al_wdata;
    word_t       al_rdata;
    logic        unused_addr_ok;

    assign unused_addr_ok = dresp.addr_ok;

    always_comb begin
        in_req             = '0;
        in_req.addr        = in_addr;
        in_req.size        = msize_t'(in_size);
        in_req.is_unsigned = in_unsigned;
        in_req.op          = (in_op == 2'b10) ? MEM_STORE : MEM_LOAD;
        in_req.wdata       = in_wdata;
    end

    assign in_mem     = (in_op == 2'b01) || (in_op == 2'b10);
    assign in_aligned = is_aligned(in_addr[2:0], msize_t'(in_size));
    assign accept     = reset && (state == IDLE) && in_valid && in_mem && in_aligned && !flush;
    // In BUSY only the latched copy reaches the bus, so in_* may wander freely.
    assign active     = accept || (reset && (state == BUSY));
    assign cur        = (state == BUSY) ? req_q : in_req;

    mem_align u_align (
        .size        (cur.size),
        .offset      (cur.addr[2:0]),
        .is_unsigned (cur.is_unsigned),
        .wdata       (cur.wdata),
        .rdata       (dresp.data),
        .strobe      (al_strobe),
        .wdata_out   (al_wdata),
        .rdata_out   (al_rdata)
    );

    always_comb begin
        dreq        = '0;
        dreq.valid  = active;
        dreq.addr   = cur.addr;
        dreq.size   = cur.size;
        dreq.strobe = (cur.op == MEM_STORE) ? al_strobe : 8'h00;
        dreq.data   = (cur.op == MEM_STORE) ? al_wdata : '0;
    end

    assign stall      = active && !dresp.data_ok;
    assign out_valid  = active && dresp.data_ok && ((state == IDLE) || !drop);
    assign out_rdata  = (out_valid && (cur.op == MEM_LOAD)) ? al_rdata : '0;
    assign misaligned = reset && (state == IDLE) && in_valid && in_mem && !in_aligned && !flush;
    assign dbg_state  = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            req_q       <= '0;
            drop        <= 1'b0;
            wait_cnt    <= '0;
            bus_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        req_q <= in_req;
                        drop  <= 1'b0;
                        if (!dresp.data_ok) state <= BUSY;
                    end
                end
                BUSY: begin
                    if (flush) drop <= 1'b1;
                    if (dresp.data_ok) begin
                        state    <= IDLE;
                        drop     <= 1'b0;
                        wait_cnt <= '0;
                    end else begin
                        if (wait_cnt != '1) wait_cnt <= wait_cnt + 32'd1;
                        // The timeout only flags a hung bus; the request keeps waiting.
                        if ((MAX_W != 32'd0) && (wait_cnt + 32'd1 >= MAX_W)) bus_timeout <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
